// File: rtl/gates2_tester.sv
// Stimulus/response checker for gates2: applies the four (a,b) vectors, samples z
// after a settle window and accumulates error count, per-vector flags and first-failure data.
module gates2_tester #(
  parameter int HOLD_CYCLES   = 200,
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic [5:0]       z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec,
  output logic [1:0]       first_fail_idx,
  output logic [5:0]       first_fail_z
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, CHECK, HOLD, DONE} state_t;

  state_t          state;
  logic [1:0]      idx;
  logic [CW-1:0]   cnt;
  logic [1:0]      nxt_idx;

  // Golden truth table: {AND, NAND, OR, NOR, XOR, XNOR} for vector index i.
  function automatic logic [5:0] exp_z(input logic [1:0] i);
    logic [5:0] r;
    case (i)
      2'd0:    r = 6'b010101;
      2'd1:    r = 6'b011010;
      2'd2:    r = 6'b011010;
      default: r = 6'b101001;
    endcase
    return r;
  endfunction

  assign nxt_idx = idx + 2'd1;
  assign pass    = done && (err_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      cnt            <= '0;
      a              <= 1'b0;
      b              <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_count      <= '0;
      fail_vec       <= '0;
      first_fail_idx <= '0;
      first_fail_z   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            err_count      <= '0;
            fail_vec       <= '0;
            first_fail_idx <= '0;
            first_fail_z   <= '0;
            done           <= 1'b0;
            busy           <= 1'b1;
            idx            <= '0;
            a              <= 1'b0;
            b              <= 1'b0;
            cnt            <= '0;
            state          <= SETTLE;
          end
        end
        SETTLE: begin
          cnt <= cnt + 1'b1;
          if (cnt == SETTLE_LAST) state <= CHECK;
        end
        CHECK: begin
          cnt <= cnt + 1'b1;
          if (z != exp_z(idx)) begin
            fail_vec[idx] <= 1'b1;
            if (err_count != '1) err_count <= err_count + ERR_W'(1);
            // fail_vec still reflects only earlier vectors, so zero means first failure
            if (fail_vec == '0) begin
              first_fail_idx <= idx;
              first_fail_z   <= z;
            end
          end
          state <= HOLD;
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            if (idx == 2'd3) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= nxt_idx;
              a     <= nxt_idx[0];
              b     <= nxt_idx[1];
              cnt   <= '0;
              state <= SETTLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gates2_tester.md
Name: gates2_tester

Overview:
- Self-checking stimulus/response engine for the gates2 block; the hardware counterpart of its simulation fixture.
- On a start pulse it drives the four input combinations (a,b) = 00, 10, 01, 11 into gates2, holds each one for a fixed time, and samples z[5:0] after a settle window.
- It compares z against the golden gate truth table and reports error count, per-vector failure flags and first-failure capture.
- Sits between board switches/buttons and gates2 on the lab target; status is shown on LEDs.

Parameters:
- HOLD_CYCLES, 200, clock cycles each vector is held on a/b; must be >= SETTLE_CYCLES+2.
- SETTLE_CYCLES, 2, cycles after a vector is applied before z is sampled; must be >= 1.
- ERR_W, 3, width of err_count.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  run request; sampled only in IDLE or DONE.
- a  out  1  stimulus to gates2 input a (registered).
- b  out  1  stimulus to gates2 input b (registered).
- z  in  6  gates2 outputs: z[5]=AND, z[4]=NAND, z[3]=OR, z[2]=NOR, z[1]=XOR, z[0]=XNOR.
- busy  out  1  high while vectors are being applied.
- done  out  1  sticky completion flag.
- pass  out  1  done && err_count==0.
- err_count  out  ERR_W  number of mismatching vectors; saturates at all-ones.
- fail_vec  out  4  bit i set if vector index i mismatched.
- first_fail_idx  out  2  index of the first failing vector.
- first_fail_z  out  6  z value sampled at the first failure.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; a=b=0; busy=done=0.
  - err_count=0, fail_vec=0, first_fail_idx=0, first_fail_z=0.
  - Reset asserted mid-run aborts the run immediately, with no partial status retained.
- Vector index i=0..3 maps to (a,b) = (0,0), (1,0), (0,1), (1,1).
- Expected z per index:
  - i=0: 6'b010101
  - i=1: 6'b011010
  - i=2: 6'b011010
  - i=3: 6'b101001
- IDLE / DONE:
  - start=1 at an edge clears all status outputs, sets i=0, drives a/b to vector 0, sets busy=1, and goes to SETTLE with cnt=0.
  - start=0 holds the current state; done and status outputs remain stable.
- SETTLE: cnt increments each cycle. When cnt==SETTLE_CYCLES-1, go to CHECK.
  - z is therefore sampled on the (SETTLE_CYCLES+1)th rising edge after a/b change.
- CHECK (one cycle): compare z with expected[i].
  - On mismatch: set fail_vec[i]; increment err_count unless it is already all-ones.
  - On the first mismatch of a run: also load first_fail_idx=i and first_fail_z=z.
  - Go to HOLD.
- HOLD: continue counting until the vector has been applied for exactly HOLD_CYCLES cycles in total.
  - If i<3: increment i, drive the new vector, cnt=0, go to SETTLE.
  - If i==3: busy=0, done=1, go to DONE.
- Timing:
  - a/b are stable for exactly HOLD_CYCLES cycles per vector.
  - done rises 4*HOLD_CYCLES cycles after the edge that accepted start.
  - a/b keep the last vector (1,1) in DONE and return to 0 only on reset.
- z is only sampled in CHECK; glitches on z during SETTLE or HOLD have no effect.
- start while busy is ignored; the run is neither restarted nor extended.
- start held continuously high: a new run begins on the edge after DONE is entered, and status is cleared at that edge.
- Values for test/bench runs (keep simulation short): HOLD_CYCLES=8, SETTLE_CYCLES=2.

Test Plan:
- Correct gates2 model, one start pulse: a/b step 00→10→01→11, each held 8 cycles; done=1 and busy=0 at cycle 32; err_count=0, fail_vec=0000, pass=1.
- z[1] (XOR) stuck at 0: err_count=2, fail_vec=0110, first_fail_idx=1, first_fail_z=011000, pass=0.
- z driven as ~expected, ERR_W=2: fail_vec=1111, err_count saturates at 3, first_fail_idx=0, first_fail_z=101010.
- rst_n pulsed low during vector 2 HOLD, then start: all outputs 0 right after reset; second run with correct model gives pass=1 and fail_vec=0000.
- start pulsed again while busy (vector 1): completion still at cycle 32. Then start in DONE after a failing run: status cleared on the accepting edge, new run result reflects only the new run.
- z glitches to 000000 for one cycle in HOLD of every vector, but is correct at each CHECK: err_count=0, pass=1.
